// File: rtl/instruction_fetch.sv
// Instruction fetch stage: walks a word-aligned PC over a req/ack memory port,
// buffers fetched words in a prefetch queue and presents one {instruction, PC} per cycle.
module instruction_fetch #(
    parameter int unsigned    bus      = 32,
    parameter int unsigned    DEPTH    = 4,
    parameter logic [bus-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           rst,
    output logic           imem_req,
    output logic [bus-1:0] imem_addr,
    input  logic           imem_ack,
    input  logic [bus-1:0] imem_rdata,
    input  logic           stall,
    input  logic           branch_taken,
    input  logic [bus-1:0] branch_target,
    output logic [bus-1:0] instruction,
    output logic [bus-1:0] PCo,
    output logic           valid
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [bus-1:0] pc;
        logic [bus-1:0] insn;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t             state_q;
    logic [bus-1:0]     fetch_pc_q;
    logic               req_q;
    logic [bus-1:0]     addr_q;
    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q;
    logic [PTR_W-1:0]   tail_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic [bus-1:0]     insn_q;
    logic [bus-1:0]     pc_q;
    logic               valid_q;

    logic               push;
    logic               pop;
    logic               room_after;
    logic [bus-1:0]     target_pc;
    logic [bus-1:0]     pc_inc;
    entry_t             head_entry;
    logic               unused_target_lsb;

    // A redirect kills both the in-flight push and any pop of stale entries.
    assign push       = (state_q == REQ) && imem_ack && !branch_taken;
    assign pop        = !branch_taken && !stall && (count_q != '0);
    assign target_pc  = {branch_target[bus-1:2], 2'b00};
    assign pc_inc     = fetch_pc_q + bus'(4);
    assign head_entry = mem_q[head_q];
    assign room_after = count_d < CNT_W'(DEPTH);
    assign unused_target_lsb = ^branch_target[1:0];

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Queue storage is pure datapath; validity is tracked by head/tail/count.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[tail_q] <= '{pc: addr_q, insn: imem_rdata};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            insn_q     <= '0;
            pc_q       <= '0;
            valid_q    <= 1'b0;
        end else begin
            if (branch_taken) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (push) begin
                    tail_q <= tail_q + PTR_W'(1);
                end
                if (pop) begin
                    head_q <= head_q + PTR_W'(1);
                end
                count_q <= count_d;
            end

            // Output register: redirect forces a bubble even under stall.
            if (branch_taken) begin
                insn_q  <= '0;
                pc_q    <= '0;
                valid_q <= 1'b0;
            end else if (!stall) begin
                if (count_q != '0) begin
                    insn_q  <= head_entry.insn;
                    pc_q    <= head_entry.pc;
                    valid_q <= 1'b1;
                end else begin
                    insn_q  <= '0;
                    pc_q    <= '0;
                    valid_q <= 1'b0;
                end
            end

            if (branch_taken) begin
                fetch_pc_q <= target_pc;
                if ((state_q == IDLE) || imem_ack) begin
                    state_q <= REQ;
                    req_q   <= 1'b1;
                    addr_q  <= target_pc;
                end else begin
                    // Outstanding request must still complete; its data is dropped.
                    state_q <= DROP;
                end
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (count_q < CNT_W'(DEPTH)) begin
                            state_q <= REQ;
                            req_q   <= 1'b1;
                            addr_q  <= fetch_pc_q;
                        end
                    end
                    REQ: begin
                        if (imem_ack) begin
                            fetch_pc_q <= pc_inc;
                            if (room_after) begin
                                addr_q <= pc_inc;
                            end else begin
                                state_q <= IDLE;
                                req_q   <= 1'b0;
                            end
                        end
                    end
                    DROP: begin
                        if (imem_ack) begin
                            state_q <= REQ;
                            req_q   <= 1'b1;
                            addr_q  <= fetch_pc_q;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instruction = insn_q;
    assign PCo         = pc_q;
    assign valid       = valid_q;

    // An unacknowledged request keeps its address into the next cycle.
    a_req_stable: assert property (@(posedge clk) disable iff (rst)
        (req_q && !imem_ack) |=> (req_q && $stable(addr_q)));

    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        push |-> (count_q < CNT_W'(DEPTH)));

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a latency-programmable memory responder
// plus one task per scenario, each with inline expected-value comparisons.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] instruction;
    logic [31:0] PCo;
    logic        valid;

    int checks   = 0;
    int failures = 0;

    logic        mem_auto   = 1'b1;
    int          mem_lat    = 0;
    int          wait_cnt   = 0;
    logic        auto_ack   = 1'b0;
    logic [31:0] auto_rdata = '0;
    logic        man_ack    = 1'b0;
    logic [31:0] man_rdata  = '0;

    assign imem_ack   = mem_auto ? auto_ack   : man_ack;
    assign imem_rdata = mem_auto ? auto_rdata : man_rdata;

    instruction_fetch #(
        .bus      (32),
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instruction   (instruction),
        .PCo           (PCo),
        .valid         (valid)
    );

    always #5 clk = ~clk;

    // Memory responder: acks a request after mem_lat extra cycles, word = 0x2113_0000 + addr.
    always @(posedge clk) begin
        #1;
        if (imem_req && !rst) begin
            if (wait_cnt >= mem_lat) begin
                auto_ack   = 1'b1;
                auto_rdata = 32'h2113_0000 + imem_addr;
                wait_cnt   = 0;
            end else begin
                auto_ack = 1'b0;
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            auto_ack = 1'b0;
            wait_cnt = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Leaves rst=1 at a negedge after two reset edges.
    task automatic apply_reset;
        rst           = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        mem_auto      = 1'b1;
        mem_lat       = 0;
        man_ack       = 1'b0;
        man_rdata     = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        apply_reset();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%h exp=0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=00000000", imem_addr); end
        checks++; if (instruction !== 32'h0) begin failures++; $display("FAIL reset_insn got=%h exp=00000000", instruction); end
        checks++; if (PCo !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=00000000", PCo); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%h exp=0", valid); end
        rst = 1'b0;
    endtask

    task automatic test_free_run;
        logic [31:0] exp_pc;
        apply_reset();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL free_first_req got=%h/%h exp=1/00000000", imem_req, imem_addr); end
        @(negedge clk);
        checks++; if (valid !== 1'b0 || imem_addr !== 32'h4) begin failures++; $display("FAIL free_latency got valid=%h addr=%h exp 0/00000004", valid, imem_addr); end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_pc = 32'(4 * k);
            checks++;
            if (valid !== 1'b1 || PCo !== exp_pc || instruction !== 32'h2113_0000 + exp_pc || imem_addr !== exp_pc + 32'h8) begin
                failures++;
                $display("FAIL free_stream[%0d] got v=%h pc=%h insn=%h addr=%h exp pc=%h", k, valid, PCo, instruction, imem_addr, exp_pc);
            end
        end
    endtask

    task automatic test_stall;
        apply_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (valid !== 1'b1 || PCo !== 32'h0) begin failures++; $display("FAIL stall_pre got v=%h pc=%h exp 1/00000000", valid, PCo); end
        stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (valid !== 1'b1 || PCo !== 32'h0 || instruction !== 32'h2113_0000 || imem_req !== (i < 2)) begin
                failures++;
                $display("FAIL stall_hold[%0d] got v=%h pc=%h insn=%h req=%h exp req=%0d", i, valid, PCo, instruction, imem_req, (i < 2));
            end
        end
        stall = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (valid !== 1'b1 || PCo !== 32'(4 * k)) begin
                failures++;
                $display("FAIL stall_release[%0d] got v=%h pc=%h exp pc=%h", k, valid, PCo, 32'(4 * k));
            end
        end
    endtask

    task automatic test_delayed_ack;
        apply_reset();
        mem_lat = 3;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0 || valid !== 1'b0) begin
                failures++;
                $display("FAIL delay_wait[%0d] got req=%h addr=%h v=%h exp 1/00000000/0", i, imem_req, imem_addr, valid);
            end
        end
        @(negedge clk);
        checks++; if (imem_addr !== 32'h4 || valid !== 1'b0) begin failures++; $display("FAIL delay_capture got addr=%h v=%h exp 00000004/0", imem_addr, valid); end
        @(negedge clk);
        checks++; if (valid !== 1'b1 || PCo !== 32'h0 || instruction !== 32'h2113_0000) begin failures++; $display("FAIL delay_first got v=%h pc=%h insn=%h exp 1/00000000/21130000", valid, PCo, instruction); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin
                failures++;
                $display("FAIL delay_bubble[%0d] got v=%h req=%h addr=%h exp 0/1/00000004", i, valid, imem_req, imem_addr);
            end
        end
        @(negedge clk);
        checks++; if (valid !== 1'b0 || imem_addr !== 32'h8) begin failures++; $display("FAIL delay_second_capture got v=%h addr=%h exp 0/00000008", valid, imem_addr); end
        @(negedge clk);
        checks++; if (valid !== 1'b1 || PCo !== 32'h4) begin failures++; $display("FAIL delay_second got v=%h pc=%h exp 1/00000004", valid, PCo); end
    endtask

    task automatic test_branch_pending;
        apply_reset();
        mem_auto = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL brp_req got=%h/%h exp 1/00000000", imem_req, imem_addr); end
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0103;
        @(negedge clk);
        branch_taken = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || valid !== 1'b0) begin failures++; $display("FAIL brp_drop_hold got req=%h addr=%h v=%h exp 1/00000000/0", imem_req, imem_addr, valid); end
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL brp_drop_wait got req=%h addr=%h exp 1/00000000", imem_req, imem_addr); end
        man_ack   = 1'b1;
        man_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        man_ack = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || valid !== 1'b0) begin failures++; $display("FAIL brp_redirect got req=%h addr=%h v=%h exp 1/00000100/0", imem_req, imem_addr, valid); end
        mem_auto = 1'b1;
        @(negedge clk);
        checks++; if (valid !== 1'b0 || imem_addr !== 32'h104) begin failures++; $display("FAIL brp_no_stale got v=%h pc=%h addr=%h exp v=0 addr=00000104", valid, PCo, imem_addr); end
        @(negedge clk);
        checks++; if (valid !== 1'b1 || PCo !== 32'h100 || instruction !== 32'h2113_0100) begin failures++; $display("FAIL brp_target got v=%h pc=%h insn=%h exp 1/00000100/21130100", valid, PCo, instruction); end
    endtask

    task automatic test_branch_ack_stall;
        apply_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (valid !== 1'b1 || PCo !== 32'h0) begin failures++; $display("FAIL bas_pre got v=%h pc=%h exp 1/00000000", valid, PCo); end
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0200;
        stall         = 1'b1;
        @(negedge clk);
        branch_taken = 1'b0;
        stall        = 1'b0;
        checks++;
        if (valid !== 1'b0 || PCo !== 32'h0 || instruction !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            failures++;
            $display("FAIL bas_bubble got v=%h pc=%h insn=%h req=%h addr=%h exp 0/0/0/1/00000200", valid, PCo, instruction, imem_req, imem_addr);
        end
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL bas_flushed got v=%h pc=%h exp v=0", valid, PCo); end
        @(negedge clk);
        checks++; if (valid !== 1'b1 || PCo !== 32'h200 || instruction !== 32'h2113_0200) begin failures++; $display("FAIL bas_target got v=%h pc=%h insn=%h exp 1/00000200/21130200", valid, PCo, instruction); end
    endtask

    task automatic test_branch_in_drop;
        apply_reset();
        mem_auto = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0040;
        @(negedge clk);
        branch_target = 32'h0000_0082;
        @(negedge clk);
        branch_taken = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL bid_hold got req=%h addr=%h exp 1/00000000", imem_req, imem_addr); end
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h80 || valid !== 1'b0) begin failures++; $display("FAIL bid_retarget got req=%h addr=%h v=%h exp 1/00000080/0", imem_req, imem_addr, valid); end
    endtask

    task automatic test_mid_reset;
        apply_reset();
        mem_auto = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL mrst_req got=%h exp 1", imem_req); end
        rst       = 1'b1;
        man_ack   = 1'b1;
        man_rdata = 32'hBAD0_BAD0;
        repeat (2) @(negedge clk);
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || valid !== 1'b0) begin failures++; $display("FAIL mrst_in_reset got req=%h addr=%h v=%h exp 0/00000000/0", imem_req, imem_addr, valid); end
        rst     = 1'b0;
        man_ack = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || valid !== 1'b0) begin failures++; $display("FAIL mrst_restart got req=%h addr=%h v=%h exp 1/00000000/0", imem_req, imem_addr, valid); end
        mem_auto = 1'b1;
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL mrst_empty got v=%h insn=%h exp v=0", valid, instruction); end
        @(negedge clk);
        checks++; if (valid !== 1'b1 || PCo !== 32'h0 || instruction !== 32'h2113_0000) begin failures++; $display("FAIL mrst_first got v=%h pc=%h insn=%h exp 1/00000000/21130000", valid, PCo, instruction); end
    endtask

    task automatic test_wrap;
        logic [31:0] exp_addr [3];
        logic [31:0] exp_pc   [3];
        exp_addr[0] = 32'hFFFF_FFF8; exp_addr[1] = 32'hFFFF_FFFC; exp_addr[2] = 32'h0000_0000;
        exp_pc[0]   = 32'hFFFF_FFF8; exp_pc[1]   = 32'hFFFF_FFFC; exp_pc[2]   = 32'h0000_0000;
        apply_reset();
        rst = 1'b0;
        @(negedge clk);
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFF8;
        @(negedge clk);
        branch_taken = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (imem_addr !== exp_addr[i]) begin
                failures++;
                $display("FAIL wrap_addr[%0d] got=%h exp=%h", i, imem_addr, exp_addr[i]);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i == 0 && imem_addr !== exp_addr[2]) begin
                failures++;
                $display("FAIL wrap_addr[2] got=%h exp=%h", imem_addr, exp_addr[2]);
            end
            if (valid !== 1'b1 || PCo !== exp_pc[i] || instruction !== 32'h2113_0000 + exp_pc[i]) begin
                failures++;
                $display("FAIL wrap_out[%0d] got v=%h pc=%h insn=%h exp pc=%h", i, valid, PCo, instruction, exp_pc[i]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_delayed_ack();
        test_branch_pending();
        test_branch_ack_stall();
        test_branch_in_drop();
        test_mid_reset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
